// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder RAM/console bus slave.
package mem_responder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  localparam logic [15:0] CON_DATA_OFS = 16'd0;
  localparam logic [15:0] CON_STAT_OFS = 16'd2;

endpackage

// File: rtl/console_fifo.sv
// Console transmit FIFO: byte storage, wrap-bit pointers, full/empty and a sticky overflow flag.
module console_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop_req,
  input  logic       clr_ovf,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       ovf
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        pop, push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop     = pop_req && !empty;
  // A pop frees the slot on the same edge, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);
  assign head    = empty ? 8'h00 : mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PW+1)'(1);
      if (push && !push_ok) ovf <= 1'b1;
      else if (clr_ovf)     ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push_ok) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_responder.sv
// Core-side RAM responder with byte-write read-modify-write and a console TX register window.
// Console FIFO and status register are built only when MEM_RESPONDER_CONSOLE_EN is defined.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 4096,
  parameter logic [15:0] CONSOLE_BASE = 16'hFF00,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] RAMaddr,
  input  logic [15:0] RAMin,
  input  logic        we,
  input  logic        be,
  output logic [15:0] RAMout,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [15:0] DATA_ADDR = CONSOLE_BASE + CON_DATA_OFS;
  localparam logic [15:0] STAT_ADDR = CONSOLE_BASE + CON_STAT_OFS;

  logic [15:0]   mem [DEPTH_WORDS];
  state_t        state, state_nxt;
  logic [14:0]   word_idx;
  logic [AW-1:0] ram_idx, m_idx;
  logic          is_data, is_stat, is_ram, idle;
  logic          byte_wr, word_wr, rd;
  logic          m_lane;
  logic [7:0]    m_byte;
  logic [15:0]   m_word, merged, ram_word, rd_word, rd_val, stat_word;

  assign word_idx = RAMaddr[15:1];
  assign ram_idx  = word_idx[AW-1:0];
  assign is_data  = (word_idx == DATA_ADDR[15:1]);
  assign is_stat  = (word_idx == STAT_ADDR[15:1]);
  assign is_ram   = !is_data && !is_stat && ({17'd0, word_idx} < DEPTH_WORDS);
  assign idle     = (state == IDLE);
  assign busy     = (state == MERGE);

  assign byte_wr  = idle && we && be && is_ram;
  assign word_wr  = idle && we && !be && is_ram;
  assign rd       = idle && !we;

  assign ram_word = mem[ram_idx];
  assign merged   = m_lane ? {m_byte, m_word[7:0]} : {m_word[15:8], m_byte};
  assign rd_word  = is_ram ? ram_word : (is_stat ? stat_word : 16'h0000);
  assign rd_val   = be ? {8'h00, (RAMaddr[0] ? rd_word[15:8] : rd_word[7:0])} : rd_word;

`ifdef MEM_RESPONDER_CONSOLE_EN
  logic con_push, stat_rd, con_empty, con_full, con_ovf;

  assign con_push = idle && we && is_data;
  assign stat_rd  = rd && is_stat;
  assign tx_valid = !con_empty;

  always_comb begin
    stat_word           = '0;
    stat_word[ST_EMPTY] = con_empty;
    stat_word[ST_FULL]  = con_full;
    stat_word[ST_OVF]   = con_ovf;
  end

  console_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (con_push),
    .push_data (RAMin[7:0]),
    .pop_req   (tx_ready),
    .clr_ovf   (stat_rd),
    .head      (tx_data),
    .empty     (con_empty),
    .full      (con_full),
    .ovf       (con_ovf)
  );
`else
  logic unused_tx_ready;

  assign unused_tx_ready = tx_ready;
  assign stat_word       = '0;
  assign tx_data         = 8'h00;
  assign tx_valid        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (byte_wr) state_nxt = MERGE;
      MERGE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)  RAMout <= '0;
    else if (rd) RAMout <= rd_val;
  end

  // RAM has no reset; writes are gated so a reset during MERGE abandons the merge.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (word_wr)    mem[ram_idx] <= RAMin;
      else if (busy)  mem[m_idx]   <= merged;
    end
    if (byte_wr) begin
      m_idx  <= ram_idx;
      m_lane <= RAMaddr[0];
      m_byte <= RAMin[7:0];
      m_word <= ram_word;
    end
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's RAM bus: it accepts `RAMaddr`/`RAMin`/`we`/`be` from the core and returns `RAMout`. It is backed by a single-port, word-wide RAM with no byte lanes, so byte writes run as a 2-cycle read-modify-write. A memory-mapped console transmit FIFO is decoded at the top of the address space. It sits between the core and the on-chip RAM and exposes a `busy` stall for RMW cycles.

## Interface
- `DEPTH_WORDS`, default 4096: number of 16-bit RAM words; word index = `RAMaddr[15:1]`.
- `CONSOLE_BASE`, default 16'hFF00: byte address of the console data register. Status is at `CONSOLE_BASE+2`.
- `FIFO_DEPTH`, default 4: console FIFO entries. Must be a power of two, ≥2.
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `RAMaddr` input 16: byte address from the core.
- `RAMin` input 16: write data from the core. For byte writes the byte is in `RAMin[7:0]`.
- `we` input 1: write strobe.
- `be` input 1: 1 = byte access, 0 = word access.
- `RAMout` output 16: registered read data.
- `busy` output 1: high during the RMW merge cycle. The core must hold its bus inputs while it is high.
- `tx_data` output 8: head of the console FIFO.
- `tx_valid` output 1: FIFO not empty.
- `tx_ready` input 1: downstream accepts `tx_data`.

## Operation
- **State machine**
  - States: IDLE, MERGE.
  - IDLE + `we` + `be` + RAM address → latch word index, lane `RAMaddr[0]` and `RAMin[7:0]`; read the RAM word; go to MERGE.
  - MERGE: write the merged word, then return to IDLE.
- **Byte lanes** (little-endian): `RAMaddr[0]=0` selects bits [7:0]; `RAMaddr[0]=1` selects bits [15:8].
- **Word write** (IDLE, `we`, `!be`): the whole word is written in one cycle. `RAMaddr[0]` is ignored for word accesses.
- **Reads** (`!we`): `RAMout` is updated every cycle while not busy.
  - Word read returns the full word.
  - Byte read returns the selected byte zero-extended into `RAMout[7:0]`.
- **Out of range**: a word index ≥ `DEPTH_WORDS` outside the console region drops writes and reads return 0.
- **Console data** (`CONSOLE_BASE`): a write of either width pushes `RAMin[7:0]` into the FIFO, with no RMW. Reading it returns 0.
- **Console status** (`CONSOLE_BASE+2`):
  - Bit 0 = empty, bit 1 = full, bit 2 = overflow (sticky); all other bits 0.
  - A status read clears overflow on the same edge that registers it into `RAMout`.
- **FIFO**
  - Push when full: the data is dropped and overflow is set.
  - Pop when `tx_valid && tx_ready`.
  - Push and pop in the same cycle while full: both take effect, there is no overflow, and the count is unchanged.
  - Push and pop in the same cycle while empty: the push is accepted and there is no pop.
  - Read and write pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap naturally.

## Timing
- **Reset values**: `RAMout`=0, `busy`=0, `tx_valid`=0, `tx_data`=0, state IDLE, FIFO empty, overflow 0. RAM contents are not reset.
- **Read latency**: 1 cycle. An address presented in cycle N gives data on `RAMout` after edge N+1.
- **Word write**: commits at edge N+1. A read of the same address in cycle N+1 returns the new data at N+2.
- **Byte write**: takes edges N+1 and N+2.
  - `busy` is high from edge N+1 to edge N+2.
  - Bus inputs are ignored in MERGE, and `RAMout` holds its value.
  - New data is visible from reads issued at cycle N+2.
- **Console write**: `tx_valid` rises at edge N+1 when the FIFO was empty.
- **Reset mid-MERGE**: the pending merge write is abandoned and RAM is unchanged.
- **Reset and `tx_ready` together**: reset wins and there is no pop.

## Configuration
- `MEM_RESPONDER_CONSOLE_EN` defined: the console FIFO and status register are built as described.
- `MEM_RESPONDER_CONSOLE_EN` undefined:
  - No FIFO logic is instantiated. `tx_data`=0 and `tx_valid`=0 constantly, and `tx_ready` is ignored.
  - Writes to the console addresses are dropped and reads of them return 0.

## Structure
- **Package `mem_responder_pkg`** holds:
  - the state enum (IDLE, MERGE);
  - status bit positions (empty=0, full=1, overflow=2);
  - the console register offsets (data 0, status 2).
- **Sub-module `console_fifo`** holds the FIFO storage, pointers, full/empty flags and the overflow sticky bit. It has a push/pop interface and is instantiated only under the macro.

## Test plan
- **Word write and read**: word write 16'hBEEF at 16'h0010, then read 16'h0010 → `RAMout`=16'hBEEF one cycle after the address; `busy` stays 0.
- **Byte writes**: with word 16'hBEEF at 16'h0010:
  - byte write 8'h12 at 16'h0011 → `busy` high for one cycle, then the word reads 16'h12EF;
  - byte read at 16'h0010 → 16'h00EF.
- **Out of range**: with `DEPTH_WORDS`=4096, write 16'hAAAA at 16'h2000 and read it back → 16'h0000.
- **Console overflow**:
  - push 5 bytes 8'h41..8'h45 with `tx_ready`=0 → status reads 16'h0006;
  - a second status read → 16'h0002;
  - drain with `tx_ready`=1 → `tx_data` sequence 8'h41..8'h44, then `tx_valid`=0.
- **Full FIFO, simultaneous push and pop**: with the FIFO full, push 8'h55 while `tx_ready`=1 → overflow stays 0, the FIFO remains full, and 8'h55 is the last byte out.
- **Reset mid-MERGE**: start a byte write 8'h99 at 16'h0020 (word previously 16'h1234) and assert `reset` low during MERGE → the word still reads 16'h1234, and `busy`=0 and `RAMout`=0 after reset.
